// File: rtl/multiplicand_pkg.sv
// Shared constants and types for the sequential shift-add multiplier blocks.
package multiplicand_pkg;

    localparam int unsigned MUL_WIDTH = 32;

    typedef logic [MUL_WIDTH-1:0] mul_operand_t;

endpackage : multiplicand_pkg

// File: rtl/multiplicand.sv
// Multiplicand holding register: captures the operand on the write strobe and
// presents it unchanged to the adder for the rest of the multiply.
module multiplicand
    import multiplicand_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] Multiplicand_in,
    input  logic             wrctrl,
    output logic [WIDTH-1:0] Multiplicand_out
);

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mcand_d;

    always_comb begin
        mcand_d = mcand_q;
        if (wrctrl) begin
            mcand_d = Multiplicand_in;
        end
    end

    // Active-low clear overrides any write strobe arriving while it is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand_q <= '0;
        end else begin
            mcand_q <= mcand_d;
        end
    end

    assign Multiplicand_out = mcand_q;

endmodule : multiplicand

// File: tb/tb_multiplicand.sv
// Directed self-checking bench for the multiplicand holding register.
module tb_multiplicand;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] Multiplicand_in = '0;
    logic         wrctrl = 1'b0;
    logic [W-1:0] Multiplicand_out;

    int total = 0;
    int bad   = 0;

    multiplicand #(.WIDTH(W)) dut (
        .clk              (clk),
        .reset            (reset),
        .Multiplicand_in  (Multiplicand_in),
        .wrctrl           (wrctrl),
        .Multiplicand_out (Multiplicand_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] b2b [4];
        b2b[0] = 32'h0000_0001;
        b2b[1] = 32'h8000_0000;
        b2b[2] = 32'h0000_0000;
        b2b[3] = 32'hA5A5_5A5A;

        // Power-up: reset low before any clock edge
        #1 reset = 1'b0;
        #2 check("powerup_reset", Multiplicand_out, 32'd0);

        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_after_reset", Multiplicand_out, 32'd0);
        end

        // Load 123: visible after the edge, not before
        @(negedge clk);
        Multiplicand_in = 32'd123;
        wrctrl = 1'b1;
        #1 check("load_before_edge", Multiplicand_out, 32'd0);
        tick();
        check("load_123", Multiplicand_out, 32'd123);

        // Hold with wrctrl low while input changes
        @(negedge clk);
        wrctrl = 1'b0;
        Multiplicand_in = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_123", Multiplicand_out, 32'd123);
        end

        @(negedge clk) wrctrl = 1'b1;
        tick();
        check("load_all_ones", Multiplicand_out, 32'hFFFF_FFFF);

        @(negedge clk) Multiplicand_in = 32'd123;
        tick();
        check("reload_123", Multiplicand_out, 32'd123);

        // Asynchronous reset between edges
        @(negedge clk) wrctrl = 1'b0;
        #2 reset = 1'b0;
        #1 check("async_reset_immediate", Multiplicand_out, 32'd0);

        wrctrl = 1'b1;
        Multiplicand_in = 32'd55;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("reset_blocks_write", Multiplicand_out, 32'd0);
        end

        // Recovery: release away from an edge
        @(negedge clk) reset = 1'b1;
        #1 check("release_no_edge", Multiplicand_out, 32'd0);
        tick();
        check("recover_load_55", Multiplicand_out, 32'd55);

        // Back-to-back writes with wrctrl held high
        for (int i = 0; i < 4; i++) begin
            @(negedge clk) Multiplicand_in = b2b[i];
            #1 check("b2b_before_edge", Multiplicand_out, (i == 0) ? 32'd55 : b2b[i-1]);
            tick();
            check("b2b_after_edge", Multiplicand_out, b2b[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_multiplicand
